// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: hazard and redirect arbitration, multi-cycle
// mul/div handshake with timeout abort, and saturating performance counters.
module pipeline_ctrl #(
    parameter int unsigned MD_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hz_stall,
    input  logic        br_taken_ex,
    input  logic        ex_md_valid,
    input  logic        md_done,
    input  logic        imem_ready,
    input  logic        perf_clr,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {RUN, MD_WAIT} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MD_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_md_cnt;
    logic [7:0]  w_md_cnt_nxt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        r_md_err;
    logic        w_set_err;
    logic        w_flush_evt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_md_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        md_start     = 1'b0;
        md_busy      = 1'b0;
        w_set_err    = 1'b0;
        w_flush_evt  = 1'b0;
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        if (rst) begin
            // Reset drains the pipe with bubbles and aborts any mul/div op.
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            w_state_nxt  = RUN;
            w_md_cnt_nxt = 8'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (br_taken_ex) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        w_flush_evt = 1'b1;
                    end else if (ex_md_valid) begin
                        md_start     = 1'b1;
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        w_state_nxt  = MD_WAIT;
                        w_md_cnt_nxt = 8'd1;
                    end else if (hz_stall) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (!imem_ready) begin
                        stall_pc    = 1'b1;
                        flush_if_id = 1'b1;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    // A result arriving on the timeout cycle still counts as success.
                    if (md_done) begin
                        w_state_nxt  = RUN;
                        w_md_cnt_nxt = 8'd0;
                    end else if (r_md_cnt >= TIMEOUT_C) begin
                        w_set_err    = 1'b1;
                        flush_ex_mem = 1'b1;
                        w_state_nxt  = RUN;
                        w_md_cnt_nxt = 8'd0;
                    end else begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        w_md_cnt_nxt = r_md_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt  = RUN;
                    w_md_cnt_nxt = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (stall_pc)
                r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_flush_evt)
                r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_md_err <= 1'b0;
        else if (w_set_err)
            r_md_err <= 1'b1;
    end

    assign md_err    = r_md_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MD_TIMEOUT=5; inputs driven on the
// falling edge, combinational outputs and counters sampled 1 ns later.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst, hz_stall, br_taken_ex, ex_md_valid, md_done, imem_ready, perf_clr;
  logic        stall_pc, stall_if_id, stall_id_ex;
  logic        flush_if_id, flush_id_ex, flush_ex_mem;
  logic        md_start, md_busy, md_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic [7:0]  ctl;
  int          total = 0;
  int          bad   = 0;

  // ctl bits: {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_mem, md_start, md_busy}
  localparam logic [7:0] C_IDLE  = 8'b000_000_00;
  localparam logic [7:0] C_RST   = 8'b000_111_00;
  localparam logic [7:0] C_START = 8'b111_001_10;
  localparam logic [7:0] C_WAIT  = 8'b111_001_01;
  localparam logic [7:0] C_DONE  = 8'b000_000_01;
  localparam logic [7:0] C_TOUT  = 8'b000_001_01;
  localparam logic [7:0] C_BR    = 8'b000_110_00;
  localparam logic [7:0] C_IMEM  = 8'b100_100_00;
  localparam logic [7:0] C_HZ    = 8'b110_010_00;

  always #5 clk = ~clk;

  assign ctl = {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
                flush_ex_mem, md_start, md_busy};

  pipeline_ctrl #(.MD_TIMEOUT(5)) dut (
    .clk(clk), .rst(rst), .hz_stall(hz_stall), .br_taken_ex(br_taken_ex),
    .ex_md_valid(ex_md_valid), .md_done(md_done), .imem_ready(imem_ready),
    .perf_clr(perf_clr), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .stall_id_ex(stall_id_ex), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .md_start(md_start), .md_busy(md_busy),
    .md_err(md_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive order: rst, hz, br, md_valid, md_done, imem_ready, perf_clr
  task automatic drv(input logic r, input logic h, input logic b, input logic e,
                     input logic d, input logic im, input logic pc);
    rst = r; hz_stall = h; br_taken_ex = b; ex_md_valid = e;
    md_done = d; imem_ready = im; perf_clr = pc;
  endtask

  task automatic cyc_chk(input string tag, input logic [7:0] exp);
    #1 chk(tag, {24'd0, ctl}, {24'd0, exp});
    @(negedge clk);
  endtask

  initial begin
    drv(1, 0, 0, 1, 0, 1, 0);
    @(negedge clk);
    cyc_chk("rst_outputs", C_RST);
    drv(0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("rst_md_err", {31'd0, md_err}, 32'd0);
    cyc_chk("idle", C_IDLE);

    // mul/div completes on cycle 4
    drv(0, 0, 0, 1, 0, 1, 0);
    cyc_chk("md_start", C_START);
    drv(0, 0, 0, 0, 0, 1, 0);
    cyc_chk("md_wait1", C_WAIT);
    drv(0, 1, 1, 1, 0, 0, 0);
    cyc_chk("md_wait2_ignore", C_WAIT);
    drv(0, 0, 0, 0, 0, 1, 0);
    cyc_chk("md_wait3", C_WAIT);
    drv(0, 0, 0, 0, 1, 1, 0);
    cyc_chk("md_done", C_DONE);
    cyc_chk("run_done_ignored", C_IDLE);
    #1 chk("md_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    @(negedge clk);

    // md_done coincident with timeout: success, no error
    drv(0, 0, 0, 1, 0, 1, 0);
    cyc_chk("tie_start", C_START);
    drv(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc_chk("tie_wait", C_WAIT);
    drv(0, 0, 0, 0, 1, 1, 0);
    cyc_chk("tie_done", C_DONE);
    drv(0, 0, 0, 0, 0, 1, 0);
    #1 chk("tie_md_err", {31'd0, md_err}, 32'd0);
    chk("tie_stall_cnt", {16'd0, stall_cnt}, 32'd9);
    @(negedge clk);

    // redirect beats all other requests
    drv(0, 1, 1, 1, 0, 1, 0);
    cyc_chk("br_priority", C_BR);
    drv(0, 0, 0, 0, 0, 1, 0);
    cyc_chk("br_stays_run", C_IDLE);
    #1 chk("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    @(negedge clk);

    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc_chk("imem_wait", C_IMEM);
    drv(0, 1, 0, 0, 0, 0, 0);
    cyc_chk("hz_stall", C_HZ);
    drv(0, 0, 0, 0, 0, 1, 0);
    #1 chk("imem_hz_stall_cnt", {16'd0, stall_cnt}, 32'd13);
    @(negedge clk);

    // timeout abort
    drv(0, 0, 0, 1, 0, 1, 0);
    cyc_chk("to_start", C_START);
    drv(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc_chk("to_wait", C_WAIT);
    cyc_chk("to_abort", C_TOUT);
    #1 chk("to_md_err", {31'd0, md_err}, 32'd1);
    chk("to_stall_cnt", {16'd0, stall_cnt}, 32'd18);
    cyc_chk("to_back_run", C_IDLE);

    drv(0, 1, 0, 0, 0, 1, 1);
    cyc_chk("clr_hz", C_HZ);
    drv(0, 0, 0, 0, 0, 1, 0);
    #1 chk("clr_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("clr_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("clr_md_err_kept", {31'd0, md_err}, 32'd1);
    @(negedge clk);

    // reset during MD_WAIT
    drv(0, 0, 0, 1, 0, 1, 0);
    cyc_chk("rw_start", C_START);
    drv(0, 0, 0, 0, 0, 1, 0);
    cyc_chk("rw_wait", C_WAIT);
    drv(1, 0, 0, 0, 0, 1, 0);
    cyc_chk("rw_rst_outputs", C_RST);
    drv(0, 0, 0, 0, 0, 1, 0);
    #1 chk("rw_md_err", {31'd0, md_err}, 32'd0);
    cyc_chk("rw_run_idle", C_IDLE);

    // stall counter saturation
    drv(0, 1, 0, 0, 0, 1, 0);
    repeat (65534) @(negedge clk);
    #1 chk("sat_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
    repeat (3) @(negedge clk);
    #1 chk("sat_ffff", {16'd0, stall_cnt}, 32'h0000_FFFF);
    @(negedge clk);
    drv(0, 1, 0, 0, 0, 1, 1);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 1, 0);
    #1 chk("sat_clr", {16'd0, stall_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MD_TIMEOUT, default 40: max cycles in MD_WAIT before abort; legal range 2..255.
REQ-002 Single clock domain; reset synchronous, active-high, sampled on rising clk only.
REQ-003 clk  in  1  pipeline clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 hz_stall  in  1  load-use/branch-operand stall request from hazard_unit.
REQ-006 br_taken_ex  in  1  branch/jump resolved taken in EX, PC redirect this cycle.
REQ-007 ex_md_valid  in  1  EX holds a valid multi-cycle mul/div op.
REQ-008 md_done  in  1  mul/div result valid this cycle.
REQ-009 imem_ready  in  1  instruction fetch data valid this cycle.
REQ-010 perf_clr  in  1  clear performance counters.
REQ-011 stall_pc, stall_if_id, stall_id_ex  out  1 each  hold PC / IF-ID / ID-EX registers.
REQ-012 flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  load bubble into IF-ID / ID-EX / EX-MEM.
REQ-013 md_start  out  1  one-cycle launch pulse to mul/div unit.
REQ-014 md_busy  out  1  high while FSM in MD_WAIT.
REQ-015 md_err  out  1  sticky mul/div timeout flag.
REQ-016 stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-017 FSM states RUN, MD_WAIT; stall/flush outputs combinational from state and inputs; md_start, counters, md_err registered state or derived as stated.
REQ-018 RUN priority, highest first: br_taken_ex, ex_md_valid, hz_stall, !imem_ready; only the winning action's outputs assert, all others 0.
REQ-019 RUN + br_taken_ex: flush_if_id=1, flush_id_ex=1, no stalls, md_start=0, state stays RUN; hz_stall and ex_md_valid ignored that cycle.
REQ-020 RUN + ex_md_valid (no redirect): md_start=1, stall_pc=stall_if_id=stall_id_ex=1, flush_ex_mem=1; next state MD_WAIT, timeout counter loaded to 1.
REQ-021 RUN + hz_stall (no higher): stall_pc=stall_if_id=1, flush_id_ex=1.
REQ-022 RUN + !imem_ready (no higher): stall_pc=1, flush_if_id=1; ID and later stages advance.
REQ-023 MD_WAIT, md_done=0, counter<MD_TIMEOUT: stall_pc=stall_if_id=stall_id_ex=1, flush_ex_mem=1; counter increments; br_taken_ex, hz_stall, imem_ready, ex_md_valid ignored.
REQ-024 MD_WAIT, md_done=1: all stall/flush outputs 0 (EX-MEM captures result), next state RUN, md_start stays 0.
REQ-025 MD_WAIT, md_done=0, counter==MD_TIMEOUT: md_err set, stalls 0, flush_ex_mem=1 (op dropped), next state RUN.
REQ-026 md_done and timeout in same cycle: md_done wins, md_err unchanged.
REQ-027 md_done in RUN ignored; md_start never asserts in two consecutive cycles.
REQ-028 stall_cnt increments by 1 on every cycle with stall_pc=1; flush_cnt increments on every RUN+br_taken_ex cycle; both saturate at 16'hFFFF.
REQ-029 perf_clr=1 zeroes both counters next cycle, overriding increment that cycle; md_err unaffected.
REQ-030 md_err cleared only by rst.

Reset
REQ-031 While rst=1: flush_if_id=flush_id_ex=flush_ex_mem=1, all stalls 0, md_start=0, md_busy=0.
REQ-032 After rst: state RUN, timeout counter 0, md_err=0, stall_cnt=flush_cnt=0.
REQ-033 rst in MD_WAIT aborts op: next cycle RUN, md_busy=0, no md_start until a new ex_md_valid.

Verification
REQ-034 ex_md_valid=1 cycle 0, md_done=1 cycle 4 -> md_start only cycle 0, stalls cycles 0-3, released cycle 4, stall_cnt=4.
REQ-035 MD_TIMEOUT=5, md_done never -> md_err=1 after cycle of counter==5, flush_ex_mem=1 that cycle, FSM RUN next.
REQ-036 br_taken_ex=hz_stall=ex_md_valid=1 in RUN -> flush_if_id=flush_id_ex=1, md_start=0, flush_cnt+1.
REQ-037 imem_ready=0 three cycles, no other requests -> stall_pc=flush_if_id=1 for 3 cycles, stall_cnt=3.
REQ-038 stall_cnt preloaded to 16'hFFFE by 3 stall cycles past it -> holds 16'hFFFF; perf_clr with stall -> 0.
REQ-039 rst asserted cycle 2 of MD_WAIT -> reset outputs per REQ-031, RUN afterward, md_err=0.
